// File: rtl/ysyx_24090018_pkg.sv
// Shared types and constants for the ysyx_24090018 instruction fetch unit.
package ysyx_24090018_pkg;

   localparam int PC_ADDR_DEFAULT    = 32;
   localparam int DATA_WIDTH_DEFAULT = 32;

   // addi x0, x0, 0 -- substituted for instructions that are never fetched
   localparam logic [31:0] NOP_INST = 32'h0000_0013;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      WAIT,
      HOLD,
      DRAIN
   } ifetch_state_e;

endpackage

// File: rtl/ysyx_24090018_ifetch.sv
// Single-outstanding instruction fetch unit: PC handshake -> memory read -> IDU handshake.
// Optional IFETCH_MISALIGN_CHK_EN: misaligned PCs bypass memory and return a NOP with misalign_o.
module ysyx_24090018_ifetch
   import ysyx_24090018_pkg::*;
#(
   parameter int PC_ADDR    = PC_ADDR_DEFAULT,
   parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [PC_ADDR-1:0]    pc_i,
   input  logic                  pc_valid_i,
   output logic                  pc_ready_o,
   output logic                  mem_req_valid_o,
   input  logic                  mem_req_ready_i,
   output logic [PC_ADDR-1:0]    mem_addr_o,
   input  logic                  mem_rsp_valid_i,
   input  logic [DATA_WIDTH-1:0] mem_rdata_i,
   output logic                  inst_valid_o,
   input  logic                  inst_ready_i,
   output logic [DATA_WIDTH-1:0] inst_o,
   output logic [PC_ADDR-1:0]    inst_pc_o,
`ifdef IFETCH_MISALIGN_CHK_EN
   output logic                  misalign_o,
`endif
   input  logic                  flush_i
);

   ifetch_state_e         state_q, state_d;
   logic [PC_ADDR-1:0]    pc_q;
   logic [DATA_WIDTH-1:0] inst_q;
   logic                  pc_load, inst_load, nop_load;

`ifdef IFETCH_MISALIGN_CHK_EN
   logic mis_q;
   logic pc_misaligned;
   assign pc_misaligned = (pc_i[1:0] != 2'b00);
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   // A flush always wins; the only question is whether a response is still owed by memory.
   always_comb begin
      state_d   = state_q;
      pc_load   = 1'b0;
      inst_load = 1'b0;
      nop_load  = 1'b0;
      case (state_q)
         IDLE: begin
            if (pc_valid_i && pc_ready_o) begin
               pc_load = 1'b1;
`ifdef IFETCH_MISALIGN_CHK_EN
               if (pc_misaligned) begin
                  state_d  = HOLD;
                  nop_load = 1'b1;
               end else begin
                  state_d  = REQ;
               end
`else
               state_d = REQ;
`endif
            end
         end
         REQ: begin
            if (flush_i)              state_d = mem_req_ready_i ? DRAIN : IDLE;
            else if (mem_req_ready_i) state_d = WAIT;
         end
         WAIT: begin
            if (mem_rsp_valid_i) begin
               if (flush_i) begin
                  state_d = IDLE;
               end else begin
                  state_d   = HOLD;
                  inst_load = 1'b1;
               end
            end else if (flush_i) begin
               state_d = DRAIN;
            end
         end
         HOLD: begin
            if (flush_i || inst_ready_i) state_d = IDLE;
         end
         DRAIN: begin
            if (mem_rsp_valid_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_q   <= '0;
         inst_q <= '0;
      end else begin
         if (pc_load)   pc_q   <= pc_i;
         if (inst_load) inst_q <= mem_rdata_i;
         if (nop_load)  inst_q <= DATA_WIDTH'(NOP_INST);
      end
   end

`ifdef IFETCH_MISALIGN_CHK_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)         mis_q <= 1'b0;
      else if (pc_load) mis_q <= pc_misaligned;
   end
   assign misalign_o = (state_q == HOLD) && mis_q;
`endif

   assign pc_ready_o      = (state_q == IDLE) && !flush_i;
   assign mem_req_valid_o = (state_q == REQ);
   assign mem_addr_o      = pc_q;
   assign inst_valid_o    = (state_q == HOLD);
   assign inst_o          = inst_q;
   assign inst_pc_o       = pc_q;

endmodule

// File: tb/tb_ysyx_24090018_ifetch.sv
// Self-checking bench for ysyx_24090018_ifetch: directed scenarios then randomized traffic
// checked against a transaction-level model. Honours IFETCH_MISALIGN_CHK_EN if defined.
module tb_ysyx_24090018_ifetch;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] pc_i = '0;
   logic        pc_valid_i = 1'b0;
   logic        pc_ready_o;
   logic        mem_req_valid_o;
   logic        mem_req_ready_i = 1'b0;
   logic [31:0] mem_addr_o;
   logic        mem_rsp_valid_i = 1'b0;
   logic [31:0] mem_rdata_i = '0;
   logic        inst_valid_o;
   logic        inst_ready_i = 1'b0;
   logic [31:0] inst_o;
   logic [31:0] inst_pc_o;
   logic        flush_i = 1'b0;
`ifdef IFETCH_MISALIGN_CHK_EN
   logic        misalign_o;
`endif

   int tests    = 0;
   int failures = 0;

   // Transaction-level model: what the unit is currently owed / holding
   bit          mReqOut;
   bit          mRspOwed;
   bit          mDiscard;
   bit          mHaveInst;
   bit          mMis;
   logic [31:0] mPc;
   logic [31:0] mInst;
   int          rspTimer = 0;

   ysyx_24090018_ifetch dut (
      .clk             (clk),
      .rst             (rst),
      .pc_i            (pc_i),
      .pc_valid_i      (pc_valid_i),
      .pc_ready_o      (pc_ready_o),
      .mem_req_valid_o (mem_req_valid_o),
      .mem_req_ready_i (mem_req_ready_i),
      .mem_addr_o      (mem_addr_o),
      .mem_rsp_valid_i (mem_rsp_valid_i),
      .mem_rdata_i     (mem_rdata_i),
      .inst_valid_o    (inst_valid_o),
      .inst_ready_i    (inst_ready_i),
      .inst_o          (inst_o),
      .inst_pc_o       (inst_pc_o),
`ifdef IFETCH_MISALIGN_CHK_EN
      .misalign_o      (misalign_o),
`endif
      .flush_i         (flush_i)
   );

   always #5 clk = ~clk;

   function automatic bit modelPcReady();
      return !(mReqOut || mRspOwed || mHaveInst) && !flush_i;
   endfunction

   task automatic modelReset();
      mReqOut   = 0;
      mRspOwed  = 0;
      mDiscard  = 0;
      mHaveInst = 0;
      mMis      = 0;
      mPc       = '0;
      mInst     = '0;
   endtask

   task automatic modelUpdate();
      bit misaligned;
`ifdef IFETCH_MISALIGN_CHK_EN
      misaligned = (pc_i[1:0] != 2'b00);
`else
      misaligned = 0;
`endif
      if (modelPcReady() && pc_valid_i) begin
         mPc  = pc_i;
         mMis = misaligned;
         if (misaligned) begin
            mHaveInst = 1;
            mInst     = NOP;
         end else begin
            mReqOut = 1;
         end
      end else if (mReqOut) begin
         if (mem_req_ready_i) begin
            mReqOut  = 0;
            mRspOwed = 1;
            mDiscard = flush_i;
         end else if (flush_i) begin
            mReqOut = 0;
         end
      end else if (mRspOwed) begin
         if (mem_rsp_valid_i) begin
            mRspOwed = 0;
            if (!mDiscard && !flush_i) begin
               mHaveInst = 1;
               mInst     = mem_rdata_i;
            end
         end else if (flush_i) begin
            mDiscard = 1;
         end
      end else if (mHaveInst) begin
         if (flush_i || inst_ready_i) mHaveInst = 0;
      end
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         failures++;
         $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
      end
   endtask

   // Drive one cycle's inputs (called just after a falling edge) and check against the model
   task automatic applyStimulus(input bit pv, input logic [31:0] pc, input bit mrdy,
                                input bit rsp, input logic [31:0] rd, input bit irdy, input bit fl);
      pc_valid_i      = pv;
      pc_i            = pc;
      mem_req_ready_i = mrdy;
      mem_rsp_valid_i = rsp;
      mem_rdata_i     = rd;
      inst_ready_i    = irdy;
      flush_i         = fl;
      #1;
      checkOutput("pc_ready", {31'b0, pc_ready_o}, {31'b0, modelPcReady()});
      checkOutput("mem_req_valid", {31'b0, mem_req_valid_o}, {31'b0, mReqOut});
      if (mReqOut) checkOutput("mem_addr", mem_addr_o, mPc);
      checkOutput("inst_valid", {31'b0, inst_valid_o}, {31'b0, mHaveInst});
      if (mHaveInst) begin
         checkOutput("inst", inst_o, mInst);
         checkOutput("inst_pc", inst_pc_o, mPc);
`ifdef IFETCH_MISALIGN_CHK_EN
         checkOutput("misalign", {31'b0, misalign_o}, {31'b0, mMis});
`endif
      end
   endtask

   task automatic tick();
      bit accepted;
      accepted = mReqOut && mem_req_ready_i;
      @(posedge clk);
      modelUpdate();
      if (rspTimer > 0) rspTimer--;
      if (accepted) rspTimer = $urandom_range(1, 3);
      @(negedge clk);
   endtask

   task automatic step(input bit pv, input logic [31:0] pc, input bit mrdy,
                       input bit rsp, input logic [31:0] rd, input bit irdy, input bit fl);
      applyStimulus(pv, pc, mrdy, rsp, rd, irdy, fl);
      tick();
   endtask

   task automatic resetDut();
      rst             = 1'b0;
      pc_valid_i      = 1'b0;
      mem_req_ready_i = 1'b0;
      mem_rsp_valid_i = 1'b0;
      inst_ready_i    = 1'b0;
      flush_i         = 1'b0;
      #1;
      modelReset();
      checkOutput("rst_pc_ready", {31'b0, pc_ready_o}, 32'd1);
      checkOutput("rst_mem_req_valid", {31'b0, mem_req_valid_o}, 32'd0);
      checkOutput("rst_inst_valid", {31'b0, inst_valid_o}, 32'd0);
      checkOutput("rst_mem_addr", mem_addr_o, 32'd0);
      checkOutput("rst_inst", inst_o, 32'd0);
      checkOutput("rst_inst_pc", inst_pc_o, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      logic [31:0] held;
      @(negedge clk);
      resetDut();

      // Best-case fetch: instruction visible three cycles after PC acceptance
      step(1, 32'h8000_0000, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 1, 0, 0, 0, 0);
      checkOutput("r037_req", {31'b0, mem_req_valid_o}, 32'd1);
      checkOutput("r037_addr", mem_addr_o, 32'h8000_0000);
      tick();
      step(0, 0, 0, 1, 32'h0010_0093, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 1, 0);
      checkOutput("r037_valid", {31'b0, inst_valid_o}, 32'd1);
      checkOutput("r037_inst", inst_o, 32'h0010_0093);
      checkOutput("r037_pc", inst_pc_o, 32'h8000_0000);
      tick();

      // Memory back-pressure: request and address held stable
      step(1, 32'h8000_0040, 0, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(0, 32'hFFFF_FFFC, 0, 0, 0, 0, 0);
         checkOutput("r038_req", {31'b0, mem_req_valid_o}, 32'd1);
         checkOutput("r038_addr", mem_addr_o, 32'h8000_0040);
         tick();
      end
      step(0, 0, 1, 0, 0, 0, 0);
      step(0, 0, 0, 1, 32'hCAFE_0001, 0, 0);

      // IDU back-pressure: instruction stable, no new PC accepted
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1, 32'h9000_0000, 0, 1, 32'h1234_5678, 0, 0);
         checkOutput("r039_inst", inst_o, 32'hCAFE_0001);
         checkOutput("r039_pc_ready", {31'b0, pc_ready_o}, 32'd0);
         tick();
      end
      step(0, 0, 0, 0, 0, 1, 0);

      // Flush while waiting, response arrives two cycles later and is dropped
      step(1, 32'h8000_0100, 0, 0, 0, 0, 0);
      step(0, 0, 1, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 1, 32'hDEAD_BEEF, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      checkOutput("r040_pc_ready", {31'b0, pc_ready_o}, 32'd1);
      checkOutput("r040_valid", {31'b0, inst_valid_o}, 32'd0);
      tick();

      // Reset while waiting, late response ignored
      step(1, 32'h8000_0200, 0, 0, 0, 0, 0);
      step(0, 0, 1, 0, 0, 0, 0);
      resetDut();
      step(0, 0, 0, 1, 32'h0BAD_0BAD, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 1, 0);
      checkOutput("r041_valid", {31'b0, inst_valid_o}, 32'd0);
      checkOutput("r041_idle", {31'b0, pc_ready_o}, 32'd1);
      tick();

      // Flush in HOLD drops the instruction the next cycle
      step(1, 32'h8000_0300, 1, 0, 0, 0, 0);
      step(0, 0, 1, 0, 0, 0, 0);
      step(0, 0, 0, 1, 32'h0000_AAAA, 0, 0);
      step(0, 0, 0, 0, 0, 0, 1);
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      checkOutput("r030_valid", {31'b0, inst_valid_o}, 32'd0);
      tick();

      // Misaligned PC: fetched unmodified, or replaced by NOP when checking is enabled
      step(1, 32'h8000_0002, 0, 0, 0, 0, 0);
`ifdef IFETCH_MISALIGN_CHK_EN
      applyStimulus(0, 0, 1, 0, 0, 0, 0);
      checkOutput("r042_req", {31'b0, mem_req_valid_o}, 32'd0);
      checkOutput("r042_inst", inst_o, NOP);
      checkOutput("r042_mis", {31'b0, misalign_o}, 32'd1);
      tick();
      step(0, 0, 0, 0, 0, 1, 0);
`else
      applyStimulus(0, 0, 1, 0, 0, 0, 0);
      checkOutput("r034_addr", mem_addr_o, 32'h8000_0002);
      tick();
      step(0, 0, 0, 1, 32'h0000_0033, 1, 0);
      step(0, 0, 0, 0, 0, 1, 0);
`endif

      // Randomized traffic with occasional spurious responses and resets
      rspTimer = 0;
      for (int c = 0; c < 600; c++) begin
         bit          pv, mrdy, rsp, irdy, fl;
         logic [31:0] pc;
         if ($urandom_range(0, 149) == 0) begin
            resetDut();
         end
         pv   = $urandom_range(0, 1);
         pc   = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
         mrdy = $urandom_range(0, 1);
         irdy = $urandom_range(0, 1);
         fl   = ($urandom_range(0, 7) == 0);
         rsp  = (rspTimer == 1);
         if (rspTimer == 0 && !mRspOwed && $urandom_range(0, 9) == 0) rsp = 1;
         held = $urandom;
         step(pv, pc, mrdy, rsp, held, irdy, fl);
      end

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule
